// File: rtl/obi_mem_responder.sv
// OBI-style memory responder: byte-enabled word memory behind a
// fixed-latency, in-order response pipeline with an outstanding cap.
//
// Ports:
//   clk, rst_ni        clock, async active-low reset
//   req_i/gnt_o        request handshake (gnt_o is combinational)
//   addr_i, we_i       byte address, write enable
//   be_i, wdata_i      byte enables and write data
//   stall_i            forces gnt_o low (backpressure injection)
//   rvalid_o           one-cycle response strobe per transaction
//   rdata_o, err_o     response payload, zero when rvalid_o is low
//   outstanding_o      granted-but-unresponded transaction count
module obi_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_ni,
    input  logic                                   req_i,
    output logic                                   gnt_o,
    input  logic [ADDR_WIDTH-1:0]                  addr_i,
    input  logic                                   we_i,
    input  logic [DATA_WIDTH/8-1:0]                be_i,
    input  logic [DATA_WIDTH-1:0]                  wdata_i,
    input  logic                                   stall_i,
    output logic                                   rvalid_o,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic                                   err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LAT   = RVALID_LATENCY;

    // No reset on the array: contents survive a reset pulse.
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic                  in_range;
    logic                  room;
    logic                  accept;
    logic [CNT_W-1:0]      cnt;

    // Response pipeline, stage LAT-1 drives the outputs.
    logic [LAT-1:0]        pv;
    logic [LAT-1:0]        pe;
    logic [DATA_WIDTH-1:0] pd [LAT];

    assign word_idx = addr_i >> OFF;
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = word_idx < ADDR_WIDTH'(DEPTH_WORDS);

    // A response leaving this cycle frees a slot at the same edge,
    // so a full responder can still grant while rvalid_o is high.
    assign room   = (cnt < CNT_W'(MAX_OUTSTANDING)) | rvalid_o;
    assign gnt_o  = rst_ni & req_i & ~stall_i & room;
    assign accept = req_i & gnt_o;

    always_ff @(posedge clk) begin
        if (accept && we_i && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_i[b]) begin
                    mem[mem_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= accept & ~in_range;
            // Read samples the pre-write word; writes return zero.
            pd[0] <= (accept && !we_i && in_range) ? mem[mem_idx] : '0;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign rvalid_o = pv[LAT-1];
    assign err_o    = pv[LAT-1] & pe[LAT-1];
    assign rdata_o  = pv[LAT-1] ? pd[LAT-1] : '0;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            case ({accept, rvalid_o})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign outstanding_o = cnt;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder: instance 0 uses default
// parameters, instance 1 uses latency 3 with a cap of 2.
module tb_obi_mem_responder;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [1:0]       req = '0;
    logic [1:0]       we = '0;
    logic [1:0]       stall = '0;
    logic [1:0][31:0] addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][3:0]  be = '0;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0]       err;
    logic [1:0][31:0] rdata;
    logic [1:0][1:0]  outs;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    obi_mem_responder u_dut0 (
        .clk(clk), .rst_ni(rst_ni),
        .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]),
        .stall_i(stall[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]),
        .outstanding_o(outs[0])
    );

    obi_mem_responder #(
        .DEPTH_WORDS(16),
        .RVALID_LATENCY(3),
        .MAX_OUTSTANDING(2)
    ) u_dut1 (
        .clk(clk), .rst_ni(rst_ni),
        .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]),
        .stall_i(stall[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]),
        .outstanding_o(outs[1])
    );

    function automatic int lat(int s);
        return (s == 0) ? 1 : 3;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(int s, exp_t e);
        if (s == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(int i);
        exp_t e;
        int n;
        n = (i == 0) ? q0.size() : q1.size();
        chk($sformatf("outs_le_max%0d", i), 64'(outs[i] <= 2'd2), 64'd1);
        if (!rvalid[i]) begin
            chk($sformatf("idle_zero%0d", i), {err[i], rdata[i]}, 64'd0);
        end else if (n == 0) begin
            chk($sformatf("unexpected_rvalid%0d", i), 64'd1, 64'd0);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata%0d", i), rdata[i], e.d);
            chk($sformatf("err%0d", i), err[i], e.e);
            chk($sformatf("latency%0d", i), 64'(cyc), 64'(e.c));
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic issue(int s, bit w, logic [31:0] a, logic [3:0] b,
                         logic [31:0] d, logic [31:0] xd, bit xe);
        exp_t e;
        bit got;
        got = 0;
        @(negedge clk);
        #1;
        req[s] = 1'b1;
        we[s] = w;
        addr[s] = a;
        be[s] = b;
        wdata[s] = d;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (gnt[s]) begin
                e.d = xd;
                e.e = xe;
                e.c = cyc + lat(s);
                @(posedge clk);
                push(s, e);
                got = 1;
                #1 req[s] = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            chk("grant_timeout", 64'd0, 64'd1);
            req[s] = 1'b0;
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [5:0] GNT_PAT = 6'b011011;

    initial begin
        exp_t e;
        int ptr;
        int cstart;

        // Reset: grant held low even with a request pending.
        repeat (3) @(negedge clk);
        #1 req[0] = 1'b1;
        #1 chk("gnt_in_reset", gnt[0], 0);
        chk("outs_in_reset", outs[0], 0);

        // First edge after release grants.
        @(negedge clk);
        rst_ni = 1'b1;
        we[0] = 1'b1;
        addr[0] = 32'h0;
        be[0] = 4'hf;
        wdata[0] = 32'h1234_5678;
        #1 chk("gnt_after_reset", gnt[0], 1);
        e.d = '0; e.e = 0; e.c = cyc + 1;
        @(posedge clk);
        push(0, e);
        #1 req[0] = 1'b0;

        // Instance 0: full write, partial write, aliasing, range.
        issue(0, 1, 32'h10, 4'hf, 32'hDEAD_BEEF, 32'h0, 0);
        issue(0, 0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF, 0);
        issue(0, 1, 32'h10, 4'b0010, 32'h0000_AA00, 32'h0, 0);
        issue(0, 0, 32'h10, 4'h0, 32'h0, 32'hDEAD_AAEF, 0);
        issue(0, 0, 32'h13, 4'h0, 32'h0, 32'hDEAD_AAEF, 0);
        issue(0, 0, 32'h1000, 4'h0, 32'h0, 32'h0, 1);
        issue(0, 1, 32'h1000, 4'hf, 32'hFFFF_FFFF, 32'h0, 1);
        issue(0, 0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 0);
        issue(0, 1, 32'h8, 4'hf, 32'h0, 32'h0, 0);
        issue(0, 1, 32'h8, 4'b1001, 32'hAABB_CCDD, 32'h0, 0);
        issue(0, 0, 32'h8, 4'h0, 32'h0, 32'hAA00_00DD, 0);

        // Stall for three cycles, grant on the fourth.
        @(negedge clk);
        #1;
        stall[0] = 1'b1;
        req[0] = 1'b1;
        we[0] = 1'b0;
        addr[0] = 32'h10;
        for (int k = 0; k < 3; k++) begin
            #1 chk("gnt_stalled", gnt[0], 0);
            @(negedge clk);
            #1;
        end
        stall[0] = 1'b0;
        #1 chk("gnt_unstalled", gnt[0], 1);
        e.d = 32'hDEAD_AAEF; e.e = 0; e.c = cyc + 1;
        @(posedge clk);
        push(0, e);
        #1 req[0] = 1'b0;

        // Instance 1: fill six words.
        for (int i = 0; i < 6; i++) begin
            issue(1, 1, 32'(i * 4), 4'hf, 32'hC0DE_0000 + 32'(i),
                  32'h0, 0);
        end
        idle(6);

        // Request held six cycles against latency 3, cap 2.
        ptr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            req[1] = 1'b1;
            we[1] = 1'b0;
            addr[1] = 32'(ptr * 4);
            #1 chk($sformatf("gnt_pat[%0d]", c), gnt[1], GNT_PAT[c]);
            if (gnt[1]) begin
                e.d = 32'hC0DE_0000 + 32'(ptr);
                e.e = 0;
                e.c = cyc + 3;
                push(1, e);
                ptr++;
            end
        end
        @(negedge clk);
        #1 req[1] = 1'b0;
        idle(6);

        // Reset with two reads in flight.
        issue(1, 0, 32'h0, 4'h0, 32'h0, 32'hC0DE_0000, 0);
        issue(1, 0, 32'h4, 4'h0, 32'h0, 32'hC0DE_0001, 0);
        @(negedge clk);
        #1;
        rst_ni = 1'b0;
        q1.delete();
        req[1] = 1'b1;
        #1 chk("gnt1_in_reset", gnt[1], 0);
        chk("rvalid1_in_reset", rvalid[1], 0);
        chk("outs1_in_reset", outs[1], 0);
        idle(2);
        #1;
        rst_ni = 1'b1;
        req[1] = 1'b0;
        idle(8);
        #1 chk("outs1_after_reset", outs[1], 0);
        issue(1, 0, 32'h14, 4'h0, 32'h0, 32'hC0DE_0005, 0);
        issue(1, 0, 32'h0, 4'h0, 32'h0, 32'hC0DE_0000, 0);
        issue(0, 0, 32'h10, 4'h0, 32'h0, 32'hDEAD_AAEF, 0);
        idle(8);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; multiple of 8, bytes = DATA_WIDTH/8.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024: memory depth in words; power of two.
REQ-004 SHALL have parameter RVALID_LATENCY, default 1: cycles from grant edge to rvalid; range 1..8.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 2: cap on granted-but-unresponded transactions; range 1..RVALID_LATENCY+1.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port req_i, input, 1: request valid.
REQ-009 SHALL have port gnt_o, output, 1: request granted this cycle.
REQ-010 SHALL have port addr_i, input, ADDR_WIDTH: byte address.
REQ-011 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-012 SHALL have port be_i, input, DATA_WIDTH/8: byte enables, writes only.
REQ-013 SHALL have port wdata_i, input, DATA_WIDTH: write data.
REQ-014 SHALL have port stall_i, input, 1: grant throttle for backpressure injection.
REQ-015 SHALL have port rvalid_o, output, 1: response valid, one cycle per transaction.
REQ-016 SHALL have port rdata_o, output, DATA_WIDTH: read data; 0 for writes and errors.
REQ-017 SHALL have port err_o, output, 1: error flag, qualified by rvalid_o.
REQ-018 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1): current outstanding count.

Function
REQ-019 SHALL drive gnt_o combinationally = req_i & ~stall_i & (outstanding < MAX_OUTSTANDING | rvalid_o).
REQ-020 SHALL accept a transaction on a rising edge where req_i & gnt_o.
REQ-021 SHALL compute word index = addr_i >> log2(bytes); low address bits are ignored; no misalignment error.
REQ-022 SHALL treat word index >= DEPTH_WORDS as out of range.
REQ-023 SHALL, for an accepted in-range write, update only the bytes with be_i set, at the accept edge.
REQ-024 SHALL, for an accepted in-range read, sample the memory word at the accept edge.
REQ-025 SHALL make a write at edge k visible to a read accepted at edge k+1 or later.
REQ-026 SHALL, for an out-of-range access, perform no memory update and return rdata_o=0, err_o=1.
REQ-027 SHALL implement the response path as a RVALID_LATENCY-stage shift pipeline carrying {valid, err, rdata}.
REQ-028 SHALL assert rvalid_o during the cycle following edge k+RVALID_LATENCY-1 for an accept at edge k; with latency 1 this is the cycle after the grant.
REQ-029 SHALL assert rvalid_o for exactly one cycle per accepted transaction.
REQ-030 SHALL return responses in acceptance order.
REQ-031 SHALL have no response backpressure: no rready; a response is consumed when rvalid_o is high at an edge.
REQ-032 SHALL update the outstanding count as follows: +1 on accept, -1 on a consumed response, unchanged when both occur on the same edge.
REQ-033 SHALL never let the outstanding count exceed MAX_OUTSTANDING or fall below 0.
REQ-034 SHALL support back-to-back grants every cycle when MAX_OUTSTANDING >= RVALID_LATENCY and stall_i=0.
REQ-035 SHALL drive rdata_o=0 and err_o=0 whenever rvalid_o=0.

Reset
REQ-036 SHALL, while rst_ni=0, force rvalid_o=0, err_o=0, rdata_o=0, outstanding_o=0, and clear all pipeline stages.
REQ-037 SHALL hold gnt_o=0 while rst_ni=0.
REQ-038 SHALL discard in-flight responses on reset mid-operation; no late rvalid_o after release.
REQ-039 SHALL retain memory contents across reset; contents are undefined only at power-up.
REQ-040 SHALL allow grant on the first rising edge after rst_ni deasserts.

Verification
REQ-041 SHALL be covered by: write addr 0x10, be=4'b1111, data 0xDEADBEEF; then read 0x10 -> rvalid one cycle after grant, rdata=0xDEADBEEF, err=0.
REQ-042 SHALL be covered by: write 0x10 be=4'b0010 data 0x0000AA00 over 0xDEADBEEF; read -> 0xDEADAAEF.
REQ-043 SHALL be covered by: read addr 4*DEPTH_WORDS -> err_o=1, rdata=0, memory unchanged on re-read of 0x0.
REQ-044 SHALL be covered by: RVALID_LATENCY=3, MAX_OUTSTANDING=2, req held high 6 cycles -> gnt_o pattern 1,1,0,1,1,0; outstanding_o never >2; responses in order.
REQ-045 SHALL be covered by: stall_i=1 for 3 cycles with req_i=1 -> gnt_o=0 for 3 cycles, grant on cycle 4.
REQ-046 SHALL be covered by: reset pulse with 2 reads in flight -> no rvalid_o after release, outstanding_o=0, previously written data still readable.
